uart_ram_loader: RTL and testbench

- Sits between the UART receiver and the instruction/data RAMs, directly upstream of the automatic controller.
- Accepts received bytes and writes them sequentially into the RAM selected by the controller's ram_mode.
- Raises receive_status when a complete image is stored; the controller edge-detects this signal to advance LOAD_INS -> LOAD_DAT -> PROCESS.

---
 rtl/uart_loader_pkg.sv | 13 +
 rtl/loader_status_stretch.sv | 30 +++
 rtl/uart_ram_loader.sv | 162 ++++++++++++++++
 tb/tb_uart_ram_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared state type and constants for the UART RAM loader
package uart_loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, LOAD, DONE} loader_state_t;

  localparam logic [1:0] MODE_LOAD = 2'b01;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_INS_DEPTH   = 256;
  localparam int DEF_DAT_DEPTH   = 256;
  localparam int DEF_STATUS_HOLD = 4;

endpackage

// File: rtl/loader_status_stretch.sv
// rtl/loader_status_stretch.sv - stretches a one-cycle done strobe into a HOLD-cycle status pulse
module loader_status_stretch #(
  parameter int HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic status,
  output logic last
);

  localparam int CW = $clog2(HOLD + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= CW'(HOLD);
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign status = (cnt != '0);
  // last marks the final status cycle so the FSM leaves DONE exactly when the pulse ends
  assign last   = (cnt == CW'(1));

endmodule

// File: rtl/uart_ram_loader.sv
// rtl/uart_ram_loader.sv - writes received UART bytes sequentially into the selected RAM
// Optional LOADER_LEN_HDR_EN: image preceded by a big-endian 16-bit length header.
module uart_ram_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int INS_DEPTH   = DEF_INS_DEPTH,
  parameter int DAT_DEPTH   = DEF_DAT_DEPTH,
  parameter int STATUS_HOLD = DEF_STATUS_HOLD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              ram_mode,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              receive_status,
  output logic              rx_drop
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] INS_D = CW'(INS_DEPTH);
  localparam logic [CW-1:0] DAT_D = CW'(DAT_DEPTH);

  loader_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, depth, depth_nxt, cfg_depth;
  logic          ram_mode_q;
  logic          wr_en, drop, done_start, status_last, abort;

`ifdef LOADER_LEN_HDR_EN
  logic [7:0]  len_hi, len_hi_nxt;
  logic [15:0] len_full;
  logic        len_clip, clip_set;

  assign len_full = {len_hi, rx_data};
`endif

  assign cfg_depth = ram_mode ? INS_D : DAT_D;
  // any change of target RAM mid-image invalidates the partial image
  assign abort     = (mode != MODE_LOAD) || (ram_mode != ram_mode_q);

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    depth_nxt  = depth;
    wr_en      = 1'b0;
    drop       = 1'b0;
    done_start = 1'b0;
`ifdef LOADER_LEN_HDR_EN
    len_hi_nxt = len_hi;
    clip_set   = 1'b0;
`endif
    case (state)
      DONE: begin
        drop = rx_valid;
        if (status_last) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        if (abort) begin
          drop      = rx_valid;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (state == IDLE) begin
          if (rx_valid) begin
`ifdef LOADER_LEN_HDR_EN
            len_hi_nxt = rx_data;
            state_nxt  = HDR_HI;
`else
            wr_en     = 1'b1;
            depth_nxt = cfg_depth;
            cnt_nxt   = CW'(1);
            if (cfg_depth == CW'(1)) begin
              state_nxt  = DONE;
              done_start = 1'b1;
            end else begin
              state_nxt = LOAD;
            end
`endif
          end
`ifdef LOADER_LEN_HDR_EN
        end else if (state == HDR_HI) begin
          if (rx_valid) begin
            if (len_full > 16'(cfg_depth)) begin
              depth_nxt = cfg_depth;
              clip_set  = 1'b1;
            end else begin
              depth_nxt = len_full[CW-1:0];
            end
            state_nxt = HDR_LO;
          end
        end else if ((state == HDR_LO) && (depth == '0)) begin
          drop       = rx_valid;
          state_nxt  = DONE;
          done_start = 1'b1;
`endif
        end else if (rx_valid) begin
          wr_en   = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt_nxt == depth) begin
            state_nxt  = DONE;
            done_start = 1'b1;
          end else begin
            state_nxt = LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      depth      <= '0;
      ram_mode_q <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      rx_drop    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      depth      <= depth_nxt;
      ram_mode_q <= ram_mode;
      ram_we     <= wr_en;
      rx_drop    <= drop;
      if (wr_en) begin
        ram_addr  <= cnt[ADDR_W-1:0];
        ram_wdata <= rx_data;
      end
    end
  end

`ifdef LOADER_LEN_HDR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi   <= '0;
      len_clip <= 1'b0;
    end else begin
      len_hi   <= len_hi_nxt;
      len_clip <= len_clip | clip_set;
    end
  end
`endif

  loader_status_stretch #(
    .HOLD(STATUS_HOLD)
  ) u_stretch (
    .clk   (clk),
    .reset (reset),
    .start (done_start),
    .status(receive_status),
    .last  (status_last)
  );

endmodule

// File: tb/tb_uart_ram_loader.sv
// tb/tb_uart_ram_loader.sv - self-checking bench for uart_ram_loader (two configurations)
module tb_uart_ram_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ram_mode, rx_valid;
  logic [1:0] mode;
  logic [7:0] rx_data;
  logic       we0, st0, dr0, we1, st1, dr1;
  logic [2:0] ad0, ad1;
  logic [7:0] wd0, wd1;

  int tests = 0;
  int fails = 0;

  uart_ram_loader #(.ADDR_W(3), .INS_DEPTH(4), .DAT_DEPTH(4), .STATUS_HOLD(4)) dut0 (
    .clk(clk), .reset(reset), .mode(mode), .ram_mode(ram_mode), .rx_data(rx_data),
    .rx_valid(rx_valid), .ram_we(we0), .ram_addr(ad0), .ram_wdata(wd0),
    .receive_status(st0), .rx_drop(dr0));

  uart_ram_loader #(.ADDR_W(3), .INS_DEPTH(1), .DAT_DEPTH(8), .STATUS_HOLD(2)) dut1 (
    .clk(clk), .reset(reset), .mode(mode), .ram_mode(ram_mode), .rx_data(rx_data),
    .rx_valid(rx_valid), .ram_we(we1), .ram_addr(ad1), .ram_wdata(wd1),
    .receive_status(st1), .rx_drop(dr1));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int md, input int rm, input int rv, input int rd);
    mode     = md[1:0];
    ram_mode = rm[0];
    rx_valid = rv[0];
    rx_data  = rd[7:0];
    @(posedge clk);
    #1;
  endtask

`ifdef LOADER_LEN_HDR_EN
  int ga[$], gd[$];
  int sc;

  task automatic collect();
    if (we0) begin
      ga.push_back(int'(ad0));
      gd.push_back(int'(wd0));
    end
    if (st0) sc++;
  endtask

  task automatic run_img(input string nm, input int b[$], input int ea[$], input int ed[$]);
    ga.delete();
    gd.delete();
    sc = 0;
    for (int k = 0; k < b.size(); k++) begin
      drive(1, 1, 1, b[k]);
      collect();
      drive(1, 1, 0, 0);
      collect();
    end
    repeat (8) begin
      drive(1, 1, 0, 0);
      collect();
    end
    chk({nm, "_nwrites"}, ga.size(), ea.size());
    for (int k = 0; k < ea.size() && k < ga.size(); k++) begin
      chk($sformatf("%s_addr%0d", nm, k), ga[k], ea[k]);
      chk($sformatf("%s_data%0d", nm, k), gd[k], ed[k]);
    end
    chk({nm, "_status_cycles"}, sc, 4);
  endtask
`else
  typedef struct {
    int md, rm, rv, rd, we, addr, wd, drop, st;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(int md, int rm, int rv, int rd, int we, int addr, int wd,
                              int drop, int st);
    vec_t v;
    v = '{md, rm, rv, rd, we, addr, wd, drop, st};
    tbl.push_back(v);
  endfunction

  // Reference: image progress per configuration, from the loading rules
  int ins_d[2]  = '{4, 1};
  int dat_d[2]  = '{4, 8};
  int hold_d[2] = '{4, 2};
  int m_phase[2], m_cnt[2], m_depth[2], m_left[2];
  int e_we[2], e_addr[2], e_wd[2], e_drop[2], e_st[2];
  int m_prev_rm;

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_phase[i] = 0; m_cnt[i] = 0; m_depth[i] = 0; m_left[i] = 0;
      e_we[i] = 0; e_addr[i] = 0; e_wd[i] = 0; e_drop[i] = 0; e_st[i] = 0;
    end
    m_prev_rm = 0;
  endfunction

  function automatic void model_step(int md, int rm, int rv, int rd);
    for (int i = 0; i < 2; i++) begin
      e_we[i]   = 0;
      e_drop[i] = 0;
      if (m_phase[i] == 2) begin
        e_drop[i] = rv;
        m_left[i]--;
        if (m_left[i] == 0) begin
          m_phase[i] = 0;
          m_cnt[i]   = 0;
        end
      end else if (md != 1 || rm != m_prev_rm) begin
        e_drop[i]  = rv;
        m_phase[i] = 0;
        m_cnt[i]   = 0;
      end else if (rv != 0) begin
        if (m_phase[i] == 0) m_depth[i] = (rm != 0) ? ins_d[i] : dat_d[i];
        e_we[i]   = 1;
        e_addr[i] = m_cnt[i] % 8;
        e_wd[i]   = rd;
        m_cnt[i]++;
        if (m_cnt[i] == m_depth[i]) begin
          m_phase[i] = 2;
          m_left[i]  = hold_d[i];
        end else begin
          m_phase[i] = 1;
        end
      end
      e_st[i] = (m_phase[i] == 2) ? 1 : 0;
    end
    m_prev_rm = rm;
  endfunction

  task automatic chk_inst(input int i, input int we, input int ad, input int wd, input int dr,
                          input int st);
    chk($sformatf("rnd%0d_we", i), we, e_we[i]);
    chk($sformatf("rnd%0d_drop", i), dr, e_drop[i]);
    chk($sformatf("rnd%0d_status", i), st, e_st[i]);
    if (e_we[i] != 0) begin
      chk($sformatf("rnd%0d_addr", i), ad, e_addr[i]);
      chk($sformatf("rnd%0d_wdata", i), wd, e_wd[i]);
    end
  endtask
`endif

  initial begin
    reset = 1'b0; mode = 2'b00; ram_mode = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we0", we0, 0);     chk("rst_addr0", ad0, 0); chk("rst_wdata0", wd0, 0);
    chk("rst_status0", st0, 0); chk("rst_drop0", dr0, 0);
    chk("rst_we1", we1, 0);     chk("rst_status1", st1, 0); chk("rst_drop1", dr1, 0);
    reset = 1'b1;

`ifdef LOADER_LEN_HDR_EN
    begin
      int b[$], ea[$], ed[$];
      drive(1, 1, 0, 0);
      b = '{0, 2, 'hAA, 'hBB}; ea = '{0, 1}; ed = '{'hAA, 'hBB};
      run_img("hdr_len2", b, ea, ed);
      b = '{0, 0}; ea.delete(); ed.delete();
      run_img("hdr_len0", b, ea, ed);
      chk("len_clip_clear", dut0.len_clip, 0);
      b = '{1, 0, 1, 2, 3, 4, 5}; ea = '{0, 1, 2, 3}; ed = '{1, 2, 3, 4};
      run_img("hdr_clip", b, ea, ed);
      chk("len_clip_set", dut0.len_clip, 1);
    end
`else
    add(1, 1, 0, 0,     0, 0, 0,     0, 0);
    add(1, 1, 1, 'h11,  1, 0, 'h11,  0, 0);
    add(1, 1, 1, 'h22,  1, 1, 'h22,  0, 0);
    add(1, 1, 1, 'h33,  1, 2, 'h33,  0, 0);
    add(1, 1, 1, 'h44,  1, 3, 'h44,  0, 1);
    add(1, 1, 1, 'h55,  0, 0, 0,     1, 1);
    add(1, 1, 0, 0,     0, 0, 0,     0, 1);
    add(1, 1, 0, 0,     0, 0, 0,     0, 1);
    add(1, 1, 0, 0,     0, 0, 0,     0, 0);
    add(3, 1, 1, 'h66,  0, 0, 0,     1, 0);
    add(1, 0, 0, 0,     0, 0, 0,     0, 0);
    add(1, 0, 1, 'hA0,  1, 0, 'hA0,  0, 0);
    add(1, 0, 1, 'hA1,  1, 1, 'hA1,  0, 0);
    add(2, 0, 0, 0,     0, 0, 0,     0, 0);
    add(1, 0, 1, 'hB0,  1, 0, 'hB0,  0, 0);
    add(1, 0, 1, 'hB1,  1, 1, 'hB1,  0, 0);
    add(1, 0, 1, 'hB2,  1, 2, 'hB2,  0, 0);
    add(1, 0, 1, 'hB3,  1, 3, 'hB3,  0, 1);
    add(1, 0, 0, 0,     0, 0, 0,     0, 1);
    add(1, 0, 0, 0,     0, 0, 0,     0, 1);
    add(1, 0, 0, 0,     0, 0, 0,     0, 1);
    add(1, 0, 0, 0,     0, 0, 0,     0, 0);
    add(1, 0, 1, 'hC0,  1, 0, 'hC0,  0, 0);
    add(1, 0, 1, 'hC1,  1, 1, 'hC1,  0, 0);
    add(1, 0, 1, 'hC2,  1, 2, 'hC2,  0, 0);
    add(1, 0, 1, 'hC3,  1, 3, 'hC3,  0, 1);
    add(1, 0, 0, 0,     0, 0, 0,     0, 1);
    add(1, 0, 0, 0,     0, 0, 0,     0, 1);
    add(1, 0, 0, 0,     0, 0, 0,     0, 1);
    add(1, 0, 0, 0,     0, 0, 0,     0, 0);
    add(1, 0, 1, 'hD0,  1, 0, 'hD0,  0, 0);
    add(1, 0, 1, 'hD1,  1, 1, 'hD1,  0, 0);
    add(1, 0, 1, 'hD2,  1, 2, 'hD2,  0, 0);
    add(0, 0, 1, 'hD3,  0, 0, 0,     1, 0);
    add(1, 0, 1, 'hE0,  1, 0, 'hE0,  0, 0);
    add(1, 1, 1, 'hE1,  0, 0, 0,     1, 0);
    add(1, 1, 1, 'hF0,  1, 0, 'hF0,  0, 0);
    add(1, 1, 1, 'hF1,  1, 1, 'hF1,  0, 0);
    add(1, 1, 1, 'hF2,  1, 2, 'hF2,  0, 0);

    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].md, tbl[k].rm, tbl[k].rv, tbl[k].rd);
      chk($sformatf("vec%0d_we", k), we0, tbl[k].we);
      chk($sformatf("vec%0d_drop", k), dr0, tbl[k].drop);
      chk($sformatf("vec%0d_status", k), st0, tbl[k].st);
      if (tbl[k].we != 0) begin
        chk($sformatf("vec%0d_addr", k), ad0, tbl[k].addr);
        chk($sformatf("vec%0d_wdata", k), wd0, tbl[k].wd);
      end
    end

    // asynchronous reset mid-load, taken between clock edges
    reset = 1'b0;
    #1;
    chk("async_we", we0, 0);    chk("async_addr", ad0, 0); chk("async_wdata", wd0, 0);
    chk("async_status", st0, 0); chk("async_drop", dr0, 0);
    @(negedge clk);
    reset = 1'b1;
    drive(1, 1, 0, 0);
    drive(1, 1, 1, 'h5A);
    chk("post_rst_we", we0, 1);   chk("post_rst_addr", ad0, 0); chk("post_rst_wdata", wd0, 'h5A);
    chk("depth1_we", we1, 1);     chk("depth1_status_a", st1, 1);
    drive(1, 1, 0, 0);
    chk("depth1_status_b", st1, 1);
    drive(1, 1, 0, 0);
    chk("depth1_status_end", st1, 0);

    reset = 1'b0;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    begin
      int md, rmv, rv, rd;
      rmv = 0;
      for (int n = 0; n < 3000; n++) begin
        md = ($urandom_range(0, 99) < 3) ? int'($urandom_range(0, 3)) : 1;
        if ($urandom_range(0, 99) < 3) rmv = 1 - rmv;
        rv = ($urandom_range(0, 99) < 45) ? 1 : 0;
        rd = int'($urandom_range(0, 255));
        model_step(md, rmv, rv, rd);
        drive(md, rmv, rv, rd);
        chk_inst(0, we0, ad0, wd0, dr0, st0);
        chk_inst(1, we1, ad1, wd1, dr1, st1);
      end
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
